// File: rtl/pokey_bus_arbiter.sv
// pokey_bus_arbiter: shares the POKEY register port between CPU and a FIFO-buffered aux write source.
// Define POKEY_SHADOW_EN to add a 16x8 shadow of every issued write with a combinational read port.
module pokey_bus_arbiter #(
    parameter int FIFO_DEPTH = 8,
    parameter int AUX_GAP    = 1
) (
    input  logic       clk_cpu_4x_i,
    input  logic       reset_cpu_n_i,
    input  logic       clk_cpu_i,
    input  logic       cpu_sel_i,
    input  logic       cpu_read_i,
    input  logic [3:0] cpu_addr_i,
    input  logic [7:0] cpu_wr_data_i,
    input  logic       aux_valid_i,
    output logic       aux_ready_o,
    input  logic [3:0] aux_addr_i,
    input  logic [7:0] aux_data_i,
    output logic [3:0] pk_a_o,
    output logic [7:0] pk_d_o,
    output logic       pk_r_w_n_o,
    output logic       pk_cs1_n_o,
    output logic       aux_busy_o,
`ifdef POKEY_SHADOW_EN
    input  logic [3:0] shadow_addr_i,
    output logic [7:0] shadow_data_o,
`endif
    output logic [7:0] defer_cnt_o
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ARMED} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    gap_q, gap_d, defer_q;
    logic          ready_q;
    logic [3:0]    a_q;
    logic [7:0]    d_q;
    logic [11:0]   mem_q [FIFO_DEPTH];
    logic [11:0]   head;
    logic          push, slot_free, aux_own;

    assign head      = mem_q[rd_ptr_q];
    assign push      = aux_valid_i & ready_q;
    assign slot_free = clk_cpu_i & ~cpu_sel_i;
    assign aux_own   = slot_free & (state_q == S_ARMED);
    assign count_d   = count_q + (AW+1)'(push) - (AW+1)'(aux_own);
    // Only free slots age the gap; it keeps counting while idle so a late push is not held back.
    assign gap_d     = aux_own ? 8'(AUX_GAP) : (slot_free && gap_q != 8'd0) ? gap_q - 8'd1 : gap_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (push) state_d = (AUX_GAP == 0) ? S_ARMED : S_WAIT;
            S_WAIT:  if (gap_q == 8'd0 || (slot_free && gap_q == 8'd1)) state_d = S_ARMED;
            S_ARMED: if (aux_own) state_d = (count_d == '0) ? S_IDLE : S_WAIT;
            default: state_d = S_IDLE;
        endcase
    end

    assign pk_a_o      = cpu_sel_i ? cpu_addr_i    : aux_own ? head[11:8] : a_q;
    assign pk_d_o      = cpu_sel_i ? cpu_wr_data_i : aux_own ? head[7:0]  : d_q;
    assign pk_r_w_n_o  = cpu_sel_i ? cpu_read_i : ~aux_own;
    assign pk_cs1_n_o  = ~(cpu_sel_i | aux_own);
    assign aux_ready_o = ready_q;
    assign aux_busy_o  = state_q != S_IDLE;
    assign defer_cnt_o = defer_q;

    always_ff @(posedge clk_cpu_4x_i or negedge reset_cpu_n_i) begin
        if (!reset_cpu_n_i) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            gap_q    <= '0;
            defer_q  <= '0;
            ready_q  <= 1'b1;
            a_q      <= '0;
            d_q      <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            gap_q   <= gap_d;
            ready_q <= count_d != (AW+1)'(FIFO_DEPTH);
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (aux_own) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (clk_cpu_i && cpu_sel_i && state_q == S_ARMED && defer_q != 8'hff) defer_q <= defer_q + 8'd1;
            if (!pk_cs1_n_o) begin
                a_q <= pk_a_o;
                d_q <= pk_d_o;
            end
        end
    end

    // Storage is flushed by the pointer reset, so the array itself needs no reset.
    always_ff @(posedge clk_cpu_4x_i)
        if (push) mem_q[wr_ptr_q] <= {aux_addr_i, aux_data_i};

`ifdef POKEY_SHADOW_EN
    logic [7:0] sh_q [16];

    always_ff @(posedge clk_cpu_4x_i or negedge reset_cpu_n_i) begin
        if (!reset_cpu_n_i) begin
            for (int i = 0; i < 16; i++) sh_q[i] <= '0;
        end else if (clk_cpu_i && !pk_cs1_n_o && !pk_r_w_n_o) begin
            sh_q[pk_a_o] <= pk_d_o;
        end
    end

    assign shadow_data_o = sh_q[shadow_addr_i];
`endif
endmodule

// File: tb/tb_pokey_bus_arbiter.sv
// tb_pokey_bus_arbiter: random and directed stimulus checked every cycle against a slot-level model
// of the arbiter (pending queue with issue-eligibility times, free-slot gap count, defer count).
module tb_pokey_bus_arbiter;
    localparam int DEPTH = 8;
    localparam int GAP   = 1;
    localparam int LAT   = (GAP == 0) ? 1 : 2;

    logic       clk = 1'b0, rst_n = 1'b1, clk_cpu = 1'b0;
    logic       cpu_sel = 1'b0, cpu_read = 1'b0, aux_valid = 1'b0;
    logic [3:0] cpu_addr = '0, aux_addr = '0, sh_addr = '0;
    logic [7:0] cpu_wd = '0, aux_data = '0;
    logic [3:0] pk_a;
    logic [7:0] pk_d, defer_cnt;
    logic       pk_r_w_n, pk_cs1_n, aux_ready, aux_busy;
`ifdef POKEY_SHADOW_EN
    logic [7:0] sh_data;
`endif

    pokey_bus_arbiter #(.FIFO_DEPTH(DEPTH), .AUX_GAP(GAP)) dut (
        .clk_cpu_4x_i(clk), .reset_cpu_n_i(rst_n), .clk_cpu_i(clk_cpu),
        .cpu_sel_i(cpu_sel), .cpu_read_i(cpu_read), .cpu_addr_i(cpu_addr), .cpu_wr_data_i(cpu_wd),
        .aux_valid_i(aux_valid), .aux_ready_o(aux_ready), .aux_addr_i(aux_addr), .aux_data_i(aux_data),
        .pk_a_o(pk_a), .pk_d_o(pk_d), .pk_r_w_n_o(pk_r_w_n), .pk_cs1_n_o(pk_cs1_n),
        .aux_busy_o(aux_busy),
`ifdef POKEY_SHADOW_EN
        .shadow_addr_i(sh_addr), .shadow_data_o(sh_data),
`endif
        .defer_cnt_o(defer_cnt)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_fail = 0, cyc = 0, free_since = GAP, n_aux = 0, n0;
    logic [11:0] mq[$];
    int          mrdy[$];
    logic [7:0]  mdef = '0, ld = '0, d0;
    logic [3:0]  la = '0;
    logic [7:0]  msh [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mrdy.delete();
        mdef = '0;
        la = '0;
        ld = '0;
        free_since = GAP;
        for (int i = 0; i < 16; i++) msh[i] = '0;
    endtask

    // One clk_cpu_4x cycle: compare at negedge, advance the model at posedge, change clk_cpu just after.
    task automatic step();
        logic        slot, elig, iss, push_ok;
        logic [13:0] exp_pk;
        @(negedge clk);
        slot = clk_cpu;
        elig = mq.size() != 0 && mrdy[0] <= cyc && free_since >= GAP;
        iss = slot && !cpu_sel && elig;
        exp_pk = cpu_sel ? {1'b0, cpu_read, cpu_addr, cpu_wd} : iss ? {2'b00, mq[0]} : {2'b11, la, ld};
        check("pk", {pk_cs1_n, pk_r_w_n, pk_a, pk_d}, exp_pk);
        check("status", {aux_ready, aux_busy, defer_cnt}, {mq.size() < DEPTH, mq.size() != 0, mdef});
`ifdef POKEY_SHADOW_EN
        check("shadow", sh_data, msh[sh_addr]);
`endif
        if (!pk_cs1_n && !pk_r_w_n && !cpu_sel) n_aux++;
        push_ok = aux_valid && mq.size() < DEPTH;
        @(posedge clk);
        if (!exp_pk[13]) begin
            la = exp_pk[11:8];
            ld = exp_pk[7:0];
            if (slot && !exp_pk[12]) msh[la] = ld;
        end
        if (iss) begin
            void'(mq.pop_front());
            void'(mrdy.pop_front());
            free_since = 0;
        end else if (slot && !cpu_sel) begin
            free_since++;
        end
        if (slot && cpu_sel && elig && mdef != 8'hff) mdef++;
        if (push_ok) begin
            mq.push_back({aux_addr, aux_data});
            mrdy.push_back(cyc + LAT);
        end
        cyc++;
        #1 clk_cpu = (cyc % 4 == 3);
    endtask

    task automatic do_reset();
        cpu_sel = 1'b0;
        aux_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_pk", {pk_cs1_n, pk_r_w_n, pk_a, pk_d}, {2'b11, 12'h000});
        check("rst_status", {aux_ready, aux_busy, defer_cnt}, {1'b1, 1'b0, 8'h00});
`ifdef POKEY_SHADOW_EN
        for (int i = 0; i < 16; i++) begin
            sh_addr = 4'(i);
            #1 check("rst_shadow", sh_data, 0);
        end
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        repeat (20) step();

        n0 = n_aux;
        aux_valid = 1'b1; aux_addr = 4'h1; aux_data = 8'hA5;
        step();
        aux_valid = 1'b0;
        repeat (12) step();
        check("single_issue", n_aux - n0, 1);
        check("single_busy", aux_busy, 0);

        n0 = n_aux;
        aux_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            aux_addr = 4'(i + 4);
            aux_data = 8'(8'h10 * (i + 1));
            step();
        end
        aux_valid = 1'b0;
        repeat (30) step();
        check("three_issue", n_aux - n0, 3);

        while (cyc % 4 != 3) step();
        d0 = mdef;
        n0 = n_aux;
        aux_valid = 1'b1; aux_addr = 4'h2; aux_data = 8'h5A;
        step();
        aux_valid = 1'b0;
        cpu_sel = 1'b1; cpu_read = 1'b0; cpu_addr = 4'h8; cpu_wd = 8'h3C;
        repeat (16) step();
        check("defer_hold", defer_cnt, d0 + 8'd4);
        check("hold_no_aux", n_aux - n0, 0);
        cpu_sel = 1'b0;
        repeat (8) step();
        check("hold_issue", n_aux - n0, 1);

        cpu_sel = 1'b1; cpu_read = 1'b1; aux_valid = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            aux_addr = 4'(i);
            aux_data = 8'($urandom);
            step();
        end
        check("full_ready", aux_ready, 0);
        aux_valid = 1'b0; cpu_sel = 1'b0;
        n0 = n_aux;
        repeat (80) step();
        check("fill_issued", n_aux - n0, DEPTH);

        cpu_sel = 1'b1; aux_valid = 1'b1;
        repeat (5) step();
        do_reset();
        n0 = n_aux;
        repeat (40) step();
        check("post_rst_aux", n_aux - n0, 0);

        for (int i = 0; i < 1500; i++) begin
            aux_valid = ($urandom % 10) < 4;
            aux_addr  = 4'($urandom);
            aux_data  = 8'($urandom);
            cpu_sel   = ($urandom % 10) < 3;
            cpu_read  = 1'($urandom);
            cpu_addr  = 4'($urandom);
            cpu_wd    = 8'($urandom);
            sh_addr   = 4'($urandom);
            step();
        end
        aux_valid = 1'b0; cpu_sel = 1'b0;
        repeat (150) step();
        check("drain_busy", aux_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pokey_bus_arbiter.md
Name: pokey_bus_arbiter

Overview:
- Shares the single POKEY register port between the 6502 bus and an auxiliary sound-command source (overlay beeps, attract-mode cues).
- CPU accesses always win the POKEY slot.
- Auxiliary writes are buffered in a small FIFO and issued in free phi2 slots.
- Sits between the CPU address decode and the POKEY instance inside the audio block.

Parameters:
- FIFO_DEPTH, 8, auxiliary write FIFO entries; power of two, 2..32.
- AUX_GAP, 1, minimum number of free slots between consecutive auxiliary writes; 0 means back-to-back.

Ports:
- clk_cpu_4x  in  1  6 MHz system clock.
- reset_cpu_n  in  1  asynchronous active-low reset.
- clk_cpu  in  1  1.5 MHz phi2 clock enable, 25% duty; one slot = one cycle with clk_cpu=1.
- cpu_sel  in  1  CPU decode selects POKEY in this cycle.
- cpu_read  in  1  1=read, 0=write.
- cpu_addr  in  4  CPU register address.
- cpu_wr_data  in  8  CPU write data.
- aux_valid  in  1  auxiliary write request.
- aux_ready  out  1  FIFO can accept.
- aux_addr  in  4  auxiliary register address.
- aux_data  in  8  auxiliary write data.
- pk_a  out  4  to POKEY a.
- pk_d  out  8  to POKEY d_in.
- pk_r_w_n  out  1  to POKEY r_w_n.
- pk_cs1_n  out  1  to POKEY cs1_n.
- aux_busy  out  1  FIFO non-empty or issue pending.
- defer_cnt  out  8  saturating count of slots where a pending aux write lost to the CPU.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty; state IDLE; gap counter 0; defer_cnt 0.
  - aux_ready=1, aux_busy=0.
  - pk_cs1_n=1, pk_r_w_n=1, pk_a=0, pk_d=0.
- FIFO push: on a clk_cpu_4x edge when aux_valid & aux_ready; independent of clk_cpu. aux_ready = ~full, registered.
- Simultaneous push and pop on a full FIFO is not allowed, because aux_ready is already 0.
- A push into an empty FIFO is eligible for issue in the next slot: at least 1 clk_cpu_4x cycle of latency.
- Port mux is combinational and driven every cycle:
  - CPU owner (cpu_sel=1): pk_* = CPU signals, pk_cs1_n=0.
  - Aux owner: pk_a/pk_d = FIFO head, pk_r_w_n=0, pk_cs1_n=0.
  - No owner: pk_cs1_n=1, pk_r_w_n=1; pk_a/pk_d hold their last registered values.
- Aux ownership is granted only when clk_cpu=1, state=ARMED and cpu_sel=0.
- FSM, advanced on clk_cpu_4x:
  - IDLE: FIFO empty. Go to WAIT when FIFO becomes non-empty; if AUX_GAP=0, go directly to ARMED.
  - WAIT: gap counter decrements on each slot with cpu_sel=0. Go to ARMED when the counter reaches 0.
  - ARMED: waiting for a free slot.
    - Slot with cpu_sel=1: stay ARMED; defer_cnt += 1, saturating at 255.
    - Slot with cpu_sel=0: the write is issued; pop the FIFO at the end of that cycle; reload the gap counter with AUX_GAP; go to WAIT, or to IDLE if the FIFO is now empty.
- Gap counting: only slots count; non-slot cycles never decrement the gap counter.
- CPU reads and writes are never delayed or modified.
- aux_busy = (state != IDLE).
- Reset mid-operation: FIFO is flushed; pending entries are discarded, not issued.
- Pointers: wrap modulo FIFO_DEPTH; the count register is one bit wider than the pointers.

Optional Feature:
- Macro: POKEY_SHADOW_EN.
- Defined:
  - Adds a 16x8 shadow register file updated on every issued write, CPU or aux.
  - Adds ports shadow_addr (in, 4) and shadow_data (out, 8, combinational read).
  - Reset clears all 16 entries to 0.
  - A CPU write and an aux write can never collide because slots are exclusive.
- Undefined: no shadow storage and no shadow ports.

Test Plan:
- Reset, then idle 20 cycles:
  - pk_cs1_n=1, aux_ready=1, aux_busy=0, defer_cnt=0.
- Push one aux write (addr 0x1, data 0xA5) with cpu_sel=0:
  - Exactly one slot shows pk_cs1_n=0, pk_r_w_n=0, pk_a=1, pk_d=0xA5.
  - Then aux_busy=0.
- Push 3 writes with AUX_GAP=1:
  - Issued on slots n, n+2, n+4, in FIFO order.
  - No write appears outside a clk_cpu=1 cycle.
- Hold cpu_sel=1 (write, addr 0x8, data 0x3C) for 4 consecutive slots while aux is pending:
  - All 4 slots show the CPU values.
  - defer_cnt=4.
  - Aux write issues on the 5th slot.
- Fill the FIFO with FIFO_DEPTH pushes:
  - aux_ready=0 and the extra push is ignored.
  - After one issue, aux_ready=1.
  - Total issued = FIFO_DEPTH.
- Assert reset_cpu_n=0 with 5 entries queued:
  - Outputs return to reset values immediately (asynchronous).
  - No queued write is issued after release.
  - With POKEY_SHADOW_EN, shadow_data=0 for all addresses.
